// File: rtl/alu_op_sequencer_if.sv
// Interface bundling the requester, ALU and result signals of alu_op_sequencer.
// Optional macro ALU_SEQ_CHAIN_EN adds chain0/chain1 (load operand A from the last result).
interface alu_op_sequencer_if #(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned SEL_W = 2
);
  logic             req0;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [SEL_W-1:0] sel0;
  logic             req1;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic [SEL_W-1:0] sel1;
`ifdef ALU_SEQ_CHAIN_EN
  logic             chain0;
  logic             chain1;
`endif
  logic             gnt0;
  logic             gnt1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [SEL_W-1:0] alu_sel;
  logic [WIDTH-1:0] alu_o;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             done_id;
  logic             busy;

  // Sequencer side
  modport slave (
    input  req0, a0, b0, sel0, req1, a1, b1, sel1,
`ifdef ALU_SEQ_CHAIN_EN
    input  chain0, chain1,
`endif
    input  alu_o,
    output gnt0, gnt1, alu_a, alu_b, alu_sel, result, done, done_id, busy
  );

  // Requesters plus ALU side
  modport master (
    output req0, a0, b0, sel0, req1, a1, b1, sel1,
`ifdef ALU_SEQ_CHAIN_EN
    output chain0, chain1,
`endif
    output alu_o,
    input  gnt0, gnt1, alu_a, alu_b, alu_sel, result, done, done_id, busy
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Round-robin sequencer sharing one external combinational ALU between two requesters.
// Grant latches operands onto the ALU, holds them ISSUE_HOLD cycles, captures alu_o and
// returns it with a one-cycle done pulse tagged with the owner id.
// Optional macro ALU_SEQ_CHAIN_EN: chainN=1 loads alu_a from the result register.
module alu_op_sequencer #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned ISSUE_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst,
  alu_op_sequencer_if.slave bus
);

  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(ISSUE_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] hold_cnt;
  logic             last_served;
  logic             grant_vld;
  logic             grant_id;
  logic             chain_sel;
  logic [WIDTH-1:0] next_a;
  logic [WIDTH-1:0] next_b;
  logic [SEL_W-1:0] next_sel;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next state, arbitration and Mealy grant pulses
  always_comb begin
    next_state = state;
    grant_vld  = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          grant_vld = 1'b1;
          grant_id  = ~last_served;
        end else if (bus.req0) begin
          grant_vld = 1'b1;
          grant_id  = 1'b0;
        end else if (bus.req1) begin
          grant_vld = 1'b1;
          grant_id  = 1'b1;
        end
        if (grant_vld) next_state = HOLD;
      end
      HOLD: begin
        if (hold_cnt == '0) next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
    bus.gnt0 = grant_vld && !grant_id;
    bus.gnt1 = grant_vld && grant_id;
  end

  // Operand selection for the granted requester
  always_comb begin
    next_a    = grant_id ? bus.a1   : bus.a0;
    next_b    = grant_id ? bus.b1   : bus.b0;
    next_sel  = grant_id ? bus.sel1 : bus.sel0;
    chain_sel = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    chain_sel = grant_id ? bus.chain1 : bus.chain0;
`endif
    if (chain_sel) next_a = bus.result;
  end

  // Datapath: operand latch, hold counter, result capture and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.alu_a   <= '0;
      bus.alu_b   <= '0;
      bus.alu_sel <= '0;
      bus.result  <= '0;
      bus.done    <= 1'b0;
      bus.done_id <= 1'b0;
      bus.busy    <= 1'b0;
      last_served <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      if (grant_vld) begin
        bus.alu_a   <= next_a;
        bus.alu_b   <= next_b;
        bus.alu_sel <= next_sel;
        last_served <= grant_id;
        hold_cnt    <= HOLD_LAST;
      end
      if (state == HOLD) begin
        if (hold_cnt == '0) begin
          bus.result  <= bus.alu_o;
          bus.done_id <= last_served;
        end else begin
          hold_cnt <= hold_cnt - CNT_W'(1);
        end
      end
      bus.done <= (next_state == DONE);
      bus.busy <= (next_state != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer (ISSUE_HOLD=1 and ISSUE_HOLD=3 instances).
// Chain checks run only when ALU_SEQ_CHAIN_EN is defined.
module tb_alu_op_sequencer;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_op_sequencer_if #(.WIDTH(6), .SEL_W(2)) bus1 ();
  alu_op_sequencer_if #(.WIDTH(6), .SEL_W(2)) bus3 ();

  alu_op_sequencer #(.WIDTH(6), .SEL_W(2), .ISSUE_HOLD(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  alu_op_sequencer #(.WIDTH(6), .SEL_W(2), .ISSUE_HOLD(3)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  // Reference ALU: add, sub, and, or, all mod 64
  function automatic logic [5:0] alu_model(input logic [5:0] a, input logic [5:0] b,
                                           input logic [1:0] sel);
    case (sel)
      2'd0:    alu_model = a + b;
      2'd1:    alu_model = a - b;
      2'd2:    alu_model = a & b;
      default: alu_model = a | b;
    endcase
  endfunction

  assign bus1.alu_o = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
  assign bus3.alu_o = alu_model(bus3.alu_a, bus3.alu_b, bus3.alu_sel);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus1.req0 = 1'b0; bus1.a0 = '0; bus1.b0 = '0; bus1.sel0 = '0;
    bus1.req1 = 1'b0; bus1.a1 = '0; bus1.b1 = '0; bus1.sel1 = '0;
    bus3.req0 = 1'b0; bus3.a0 = '0; bus3.b0 = '0; bus3.sel0 = '0;
    bus3.req1 = 1'b0; bus3.a1 = '0; bus3.b1 = '0; bus3.sel1 = '0;
`ifdef ALU_SEQ_CHAIN_EN
    bus1.chain0 = 1'b0; bus1.chain1 = 1'b0;
    bus3.chain0 = 1'b0; bus3.chain1 = 1'b0;
`endif
  endtask

  // Two-cycle reset; returns #1 after the negedge where rst drops
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  // One op on dut1 by a single requester, with exact latency checks
  task automatic run_single(input string tag, input logic id, input logic [5:0] a,
                            input logic [5:0] b, input logic [1:0] sel,
                            input logic chain, input logic [5:0] exp_a,
                            input logic [5:0] exp);
    @(negedge clk);
    if (id) begin
      bus1.req1 = 1'b1; bus1.a1 = a; bus1.b1 = b; bus1.sel1 = sel;
    end else begin
      bus1.req0 = 1'b1; bus1.a0 = a; bus1.b0 = b; bus1.sel0 = sel;
    end
`ifdef ALU_SEQ_CHAIN_EN
    if (id) bus1.chain1 = chain; else bus1.chain0 = chain;
`else
    if (chain) $display("note: chain ignored in %s", tag);
`endif
    #1;
    check({tag, " gnt0"}, 32'(bus1.gnt0), 32'(!id));
    check({tag, " gnt1"}, 32'(bus1.gnt1), 32'(id));
    @(negedge clk);
    bus1.req0 = 1'b0;
    bus1.req1 = 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
    bus1.chain0 = 1'b0; bus1.chain1 = 1'b0;
`endif
    #1;
    check({tag, " hold done"}, 32'(bus1.done), 32'd0);
    check({tag, " hold busy"}, 32'(bus1.busy), 32'd1);
    check({tag, " alu_a"}, 32'(bus1.alu_a), 32'(exp_a));
    check({tag, " alu_b"}, 32'(bus1.alu_b), 32'(b));
    check({tag, " alu_sel"}, 32'(bus1.alu_sel), 32'(sel));
    @(negedge clk);
    #1;
    check({tag, " done"}, 32'(bus1.done), 32'd1);
    check({tag, " result"}, 32'(bus1.result), 32'(exp));
    check({tag, " done_id"}, 32'(bus1.done_id), 32'(id));
    @(negedge clk);
    #1;
    check({tag, " done low"}, 32'(bus1.done), 32'd0);
    check({tag, " idle busy"}, 32'(bus1.busy), 32'd0);
    check({tag, " result held"}, 32'(bus1.result), 32'(exp));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    idle_inputs();

    // Reset state
    do_reset();
    check("rst gnt0", 32'(bus1.gnt0), 32'd0);
    check("rst gnt1", 32'(bus1.gnt1), 32'd0);
    check("rst done", 32'(bus1.done), 32'd0);
    check("rst done_id", 32'(bus1.done_id), 32'd0);
    check("rst busy", 32'(bus1.busy), 32'd0);
    check("rst result", 32'(bus1.result), 32'd0);
    check("rst alu_a", 32'(bus1.alu_a), 32'd0);
    check("rst alu_b", 32'(bus1.alu_b), 32'd0);
    check("rst alu_sel", 32'(bus1.alu_sel), 32'd0);

    // 1: single add 15+24
    run_single("t1", 1'b0, 6'd15, 6'd24, 2'd0, 1'b0, 6'd15, 6'd39);

    // 2: simultaneous requests after reset, req0 first then req1 (3-5 = 62)
    do_reset();
    @(negedge clk);
    bus1.req0 = 1'b1; bus1.a0 = 6'd4; bus1.b0 = 6'd2; bus1.sel0 = 2'd0;
    bus1.req1 = 1'b1; bus1.a1 = 6'd3; bus1.b1 = 6'd5; bus1.sel1 = 2'd1;
    #1;
    check("t2 gnt0", 32'(bus1.gnt0), 32'd1);
    check("t2 gnt1 lost", 32'(bus1.gnt1), 32'd0);
    @(negedge clk);
    bus1.req0 = 1'b0;
    #1;
    check("t2 hold gnt1", 32'(bus1.gnt1), 32'd0);
    @(negedge clk);
    #1;
    check("t2 done0", 32'(bus1.done), 32'd1);
    check("t2 result0", 32'(bus1.result), 32'd6);
    check("t2 id0", 32'(bus1.done_id), 32'd0);
    check("t2 done gnt1", 32'(bus1.gnt1), 32'd0);
    @(negedge clk);
    #1;
    check("t2 idle gnt1", 32'(bus1.gnt1), 32'd1);
    check("t2 idle gnt0", 32'(bus1.gnt0), 32'd0);
    @(negedge clk);
    bus1.req1 = 1'b0;
    @(negedge clk);
    #1;
    check("t2 done1", 32'(bus1.done), 32'd1);
    check("t2 result1", 32'(bus1.result), 32'd62);
    check("t2 id1", 32'(bus1.done_id), 32'd1);

    // 3: wrap passes through, then OR
    run_single("t3 wrap", 1'b1, 6'd63, 6'd1, 2'd0, 1'b0, 6'd63, 6'd0);
    run_single("t3 or", 1'b0, 6'd18, 6'd53, 2'd3, 1'b0, 6'd18, 6'd55);

    // 4: reset during HOLD aborts, arbitration pointer restored
    @(negedge clk);
    bus1.req0 = 1'b1; bus1.a0 = 6'd1; bus1.b0 = 6'd1; bus1.sel0 = 2'd0;
    #1;
    check("t4 gnt0", 32'(bus1.gnt0), 32'd1);
    @(negedge clk);
    bus1.req0 = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4 no done", 32'(bus1.done), 32'd0);
    check("t4 result", 32'(bus1.result), 32'd0);
    check("t4 busy", 32'(bus1.busy), 32'd0);
    @(negedge clk);
    #1;
    check("t4 no done late", 32'(bus1.done), 32'd0);
    bus1.req0 = 1'b1; bus1.req1 = 1'b1;
    #1;
    check("t4 rr gnt0", 32'(bus1.gnt0), 32'd1);
    check("t4 rr gnt1", 32'(bus1.gnt1), 32'd0);
    @(negedge clk);
    bus1.req0 = 1'b0; bus1.req1 = 1'b0;
    repeat (3) @(negedge clk);

    // 5: ISSUE_HOLD=3, req1 raised during HOLD waits for IDLE
    do_reset();
    @(negedge clk);
    bus3.req0 = 1'b1; bus3.a0 = 6'd5; bus3.b0 = 6'd6; bus3.sel0 = 2'd0;
    #1;
    check("t5 gnt0", 32'(bus3.gnt0), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      bus3.req0 = 1'b0;
      bus3.req1 = 1'b1; bus3.a1 = 6'd10; bus3.b1 = 6'd3; bus3.sel1 = 2'd1;
      #1;
      check($sformatf("t5 gnt1 c%0d", c), 32'(bus3.gnt1), 32'd0);
      check($sformatf("t5 done c%0d", c), 32'(bus3.done), 32'(c == 4));
    end
    check("t5 result0", 32'(bus3.result), 32'd11);
    check("t5 id0", 32'(bus3.done_id), 32'd0);
    @(negedge clk);
    #1;
    check("t5 gnt1 idle", 32'(bus3.gnt1), 32'd1);
    @(negedge clk);
    bus3.req1 = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("t5 done1", 32'(bus3.done), 32'd1);
    check("t5 result1", 32'(bus3.result), 32'd7);
    check("t5 id1", 32'(bus3.done_id), 32'd1);

`ifdef ALU_SEQ_CHAIN_EN
    // 6: chain loads alu_a from the previous result
    do_reset();
    run_single("t6 base", 1'b0, 6'd15, 6'd8, 2'd0, 1'b0, 6'd15, 6'd23);
    run_single("t6 chain", 1'b0, 6'd0, 6'd2, 2'd1, 1'b1, 6'd23, 6'd21);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
